// File: rtl/jk_pkg.sv
// jk_pkg: shared FSM states, mode encodings and JK excitation helper
package jk_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
  localparam logic MODE_HOLD = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;
  // {J,K} that moves one flop from q to d; toggle mode drives both on any change
  function automatic logic [1:0] jk_excite(input logic q, input logic d, input logic mode);
    return (q == d) ? 2'b00 : (mode == MODE_TOGGLE) ? 2'b11 : {d, ~d};
  endfunction
endpackage

// File: rtl/jk_excite_gen.sv
// jk_excite_gen: turns target Q words into one-cycle J/K pulses and verifies readback
module jk_excite_gen
  import jk_pkg::*;
#(
  parameter int W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [W-1:0]     tgt_data,
  input  logic             mode,
  input  logic             err_clr,
  output logic [W-1:0]     j_out,
  output logic [W-1:0]     k_out,
  input  logic [W-1:0]     q_in,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
);
  state_t state_q;
  logic [W-1:0] q_exp_q, tgt_q, j_q, k_q, j_d, k_d;
  logic [CNT_W-1:0] cnt_q;
  logic flag_q;
  for (genvar i = 0; i < W; i++) begin : g_exc
    assign {j_d[i], k_d[i]} = jk_excite(q_exp_q[i], tgt_data[i], mode);
  end
  // handshake, one-cycle drive pulse, readback check with resync on mismatch
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      q_exp_q <= '0;
      tgt_q <= '0;
      j_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
      flag_q <= 1'b0;
    end else begin
      if (err_clr) begin
        cnt_q <= '0;
        flag_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (tgt_valid) begin
          tgt_q <= tgt_data;
          j_q <= j_d;
          k_q <= k_d;
          state_q <= DRIVE;
        end
        DRIVE: begin
          j_q <= '0;
          k_q <= '0;
          q_exp_q <= tgt_q;
          state_q <= CHECK;
        end
        default: begin
          if (q_in != q_exp_q) begin
            cnt_q <= err_clr ? CNT_W'(1) : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            flag_q <= 1'b1;
            q_exp_q <= q_in;
          end
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign tgt_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign j_out = j_q;
  assign k_out = k_q;
  assign err_cnt = cnt_q;
  assign err_flag = flag_q;
endmodule

// File: tb/tb_jk_excite_gen.sv
// tb_jk_excite_gen: directed and random transactions against a JK flop bank load
module tb_jk_excite_gen;
  localparam int W = 4;
  localparam int CNT_W = 3;
  logic clk = 1'b0, n_rst = 1'b0;
  logic tgt_valid = 1'b0, mode = 1'b0, err_clr = 1'b0, fault = 1'b0;
  logic [W-1:0] tgt_data = '0, j_out, k_out, q_bank;
  logic tgt_ready, busy, err_flag;
  logic [CNT_W-1:0] err_cnt;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] s_m = '0;
  int cnt_m = 0;
  logic flag_m = 1'b0;

  always #5 clk = ~clk;

  jk_excite_gen #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_data(tgt_data), .mode(mode), .err_clr(err_clr), .j_out(j_out),
    .k_out(k_out), .q_in(q_bank), .busy(busy), .err_cnt(err_cnt), .err_flag(err_flag)
  );

  // load: W JK flops; fault pins flop 0 at 0
  always @(posedge clk or negedge n_rst)
    if (!n_rst) q_bank <= '0;
    else q_bank <= ((j_out & ~q_bank) | (~k_out & q_bank)) & ~{{(W-1){1'b0}}, fault};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one full transaction; the model derives J/K from the change set and the mode rule
  task automatic txn(input logic [W-1:0] t, input logic m, input logic clr, input logic keep);
    logic [W-1:0] diff, ej, ek, eb;
    diff = s_m ^ t;
    ej = m ? diff : diff & t;
    ek = m ? diff : diff & ~t;
    eb = fault ? t & ~{{(W-1){1'b0}}, 1'b1} : t;
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data = t;
    mode = m;
    @(posedge clk); #1;
    chk("busy_drive", busy, 1);
    chk("ready_drive", tgt_ready, 0);
    chk("j_drive", j_out, ej);
    chk("k_drive", k_out, ek);
    if (!keep) tgt_valid = 1'b0;
    tgt_data = $urandom;
    mode = $urandom;
    @(posedge clk); #1;
    chk("jk_idle", {j_out, k_out}, 0);
    chk("ready_check", tgt_ready, 0);
    chk("bank", q_bank, eb);
    err_clr = clr;
    @(posedge clk); #1;
    err_clr = 1'b0;
    if (clr) begin cnt_m = 0; flag_m = 1'b0; end
    if (eb != t) begin
      cnt_m = (cnt_m == 7) ? 7 : cnt_m + 1;
      flag_m = 1'b1;
    end
    s_m = eb;
    chk("ready_after", tgt_ready, 1);
    chk("err_cnt", err_cnt, cnt_m);
    chk("err_flag", err_flag, flag_m);
  endtask

  initial begin
    #12;
    chk("rst_ready", tgt_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_jk", {j_out, k_out}, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_flag", err_flag, 0);
    @(negedge clk);
    n_rst = 1'b1;
    txn(4'b1010, 1'b0, 1'b0, 1'b0);
    txn(4'b0110, 1'b0, 1'b0, 1'b0);
    txn(4'b1010, 1'b0, 1'b0, 1'b0);
    txn(4'b0110, 1'b1, 1'b0, 1'b0);
    txn(4'b0000, 1'b0, 1'b0, 1'b0);
    fault = 1'b1;
    txn(4'b0001, 1'b0, 1'b0, 1'b0);
    txn(4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) txn(4'b0001, i[0], 1'b0, 1'b0);
    chk("sat_cnt", err_cnt, 7);
    txn(4'b0001, 1'b0, 1'b1, 1'b0);
    txn(4'b0000, 1'b0, 1'b1, 1'b0);
    fault = 1'b0;
    for (int i = 0; i < 20; i++) txn(4'($urandom), 1'($urandom), 1'b0, 1'b0);
    fault = 1'b1;
    txn(4'b0011, 1'b0, 1'b0, 1'b0);
    fault = 1'b0;
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data = 4'b1111;
    @(posedge clk); #2;
    n_rst = 1'b0;
    tgt_valid = 1'b0;
    #1;
    chk("mid_jk", {j_out, k_out}, 0);
    chk("mid_ready", tgt_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_cnt", err_cnt, 0);
    chk("mid_flag", err_flag, 0);
    chk("mid_bank", q_bank, 0);
    s_m = '0; cnt_m = 0; flag_m = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", tgt_ready, 1);
    txn(4'b0101, 1'b0, 1'b0, 1'b1);
    txn(4'b1100, 1'b1, 1'b0, 1'b1);
    txn(4'b0011, 1'b0, 1'b0, 1'b1);
    txn(4'b1001, 1'b1, 1'b0, 1'b0);
    chk("b2b_final", q_bank, 4'b1001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
